// File: rtl/rr_onehot_arbiter.sv
// Four-way round-robin arbiter driving a one-hot mux select.
// Grant is registered and held for at most MAX_HOLD cycles per award.
module rr_onehot_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_vld_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [3:0] hold_q;
  logic [3:0] hold_d;
  logic [3:0] gnt_q;
  logic [3:0] gnt_d;

  logic [1:0] idx;
  logic       vld;
  logic       release_c;
  logic [1:0] base;
  logic [3:0] cand;

  // Rotate so base sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [3:0] pick(
    input logic [3:0] req,
    input logic [1:0] b
  );
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [3:0] first;
    logic [7:0] back;
    dbl   = {req, req} >> b;
    rot   = dbl[3:0];
    first = rot & (~rot + 4'd1);
    back  = {first, first} << b;
    return back[7:4];
  endfunction

  always_comb begin
    idx = 2'd0;
    unique case (1'b1)
      gnt_q[1]: idx = 2'd1;
      gnt_q[2]: idx = 2'd2;
      gnt_q[3]: idx = 2'd3;
      default:  idx = 2'd0;
    endcase
  end

  assign vld = |gnt_q;

  assign release_c = (state_q == BUSY) &&
                     (!req_i[idx] || hold_q == HOLD_MAX);

  assign base = release_c ? idx + 2'd1 : ptr_q;
  assign cand = pick(req_i, base);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|req_i) state_d = BUSY;
      BUSY: if (release_c && !(|cand)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A release re-arbitrates in the same cycle, so no gap cycle appears.
  always_comb begin
    ptr_d  = ptr_q;
    hold_d = hold_q;
    gnt_d  = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d  = cand;
          hold_d = 4'd1;
        end
      end
      BUSY: begin
        if (release_c) begin
          ptr_d = base;
          gnt_d = cand;
          hold_d = (|cand) ? 4'd1 : 4'd0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        gnt_d  = 4'd0;
        hold_d = 4'd0;
      end
    endcase
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx;
  assign gnt_vld_o = vld;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter.
// Two instances: default MAX_HOLD=4 and MAX_HOLD=1.
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [3:0] gnt_a;
  logic [1:0] idx_a;
  logic       vld_a;
  logic [3:0] gnt_b;
  logic [1:0] idx_b;
  logic       vld_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_a),
    .gnt_o     (gnt_a),
    .gnt_idx_o (idx_a),
    .gnt_vld_o (vld_a)
  );

  rr_onehot_arbiter #(.MAX_HOLD(1)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_b),
    .gnt_o     (gnt_b),
    .gnt_idx_o (idx_b),
    .gnt_vld_o (vld_b)
  );

  function automatic logic [1:0] exp_idx(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] g,
                     input logic [1:0] i, input logic v,
                     input logic [3:0] exp);
    cmp({tag, ".gnt"}, g, exp);
    cmp({tag, ".idx"}, {2'b00, i}, {2'b00, exp_idx(exp)});
    cmp({tag, ".vld"}, {3'b000, v}, {3'b000, |exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #1;
    chk("rst_a", gnt_a, idx_a, vld_a, 4'b0000);
    chk("rst_b", gnt_b, idx_b, vld_b, 4'b0000);
    tick();
    #2;
    reset_n = 1'b1;
  endtask

  logic [3:0] seq28 [9];
  logic [3:0] seq31 [5];

  initial begin
    reset_n = 1'b1;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    seq28 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
              4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010};
    seq31 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    #3;

    // idle with no requests
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle", gnt_a, idx_a, vld_a, 4'b0000);
    end

    // two requesters, hold limit rotation
    do_reset();
    req_a = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rot%0d", i), gnt_a, idx_a, vld_a, seq28[i]);
    end

    // holder drops, handoff with no gap
    do_reset();
    req_a = 4'b0011;
    tick();
    chk("drop1", gnt_a, idx_a, vld_a, 4'b0001);
    tick();
    chk("drop2", gnt_a, idx_a, vld_a, 4'b0001);
    req_a = 4'b0010;
    tick();
    chk("drop3", gnt_a, idx_a, vld_a, 4'b0010);

    // sole requester re-granted back-to-back
    do_reset();
    req_a = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sole%0d", i), gnt_a, idx_a, vld_a, 4'b0001);
    end
    req_a = 4'b0000;
    #1;
    chk("lag", gnt_a, idx_a, vld_a, 4'b0001);
    tick();
    chk("lag_clr", gnt_a, idx_a, vld_a, 4'b0000);

    // MAX_HOLD=1 rotates every cycle
    do_reset();
    req_b = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("mh1_%0d", i), gnt_b, idx_b, vld_b, seq31[i]);
    end
    req_b = 4'b0000;

    // async reset mid-grant, then restart from pointer 0
    do_reset();
    req_a = 4'b1000;
    tick();
    chk("g3", gnt_a, idx_a, vld_a, 4'b1000);
    req_a = 4'b0100;
    tick();
    chk("g2", gnt_a, idx_a, vld_a, 4'b0100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async", gnt_a, idx_a, vld_a, 4'b0000);
    req_a = 4'b1111;
    #1;
    reset_n = 1'b1;
    tick();
    chk("post", gnt_a, idx_a, vld_a, 4'b0001);
    tick();
    chk("post2", gnt_a, idx_a, vld_a, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
